univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
- Parametrised successor to the team's 2-bit flip-flop register: a WIDTH-bit universal register.
- Supports per-cycle hold, parallel load, and single-step shift/rotate in either direction.
- Adds a multi-cycle burst-shift engine: shifts by a programmed amount, with busy/done status.
- Used as a general storage/serialiser element in datapath labs; all state advances only on clk edges with clk_en high.

Parameters:
WIDTH, 8, register width in bits (>=2)
RESET_VAL, 0, value loaded into q on reset
AW, $clog2(WIDTH)+1, width of the burst amount input (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clk_en  input  1  clock enable; low freezes all state, including the burst FSM
mode  input  2  idle-time operation: 00 hold, 01 parallel load, 10 shift left, 11 shift right
rotate  input  1  1: wrap the shifted-out bit back in; 0: fill with ser_in
ser_in  input  1  serial fill bit
d  input  WIDTH  parallel load data
start  input  1  burst request (level sampled on an enabled edge)
dir  input  1  burst direction: 0 left, 1 right
amt  input  AW  burst shift count
q  output  WIDTH  register contents
ser_out  output  1  registered copy of the bit shifted out by the most recent shift
busy  output  1  burst in progress
done  output  1  one-cycle pulse when a burst completes

Behaviour:
- Reset (rst_n low, asynchronous, independent of clk/clk_en):
  - q=RESET_VAL, ser_out=0, busy=0, done=0, FSM=IDLE, counter=0.
  - Reset mid-burst aborts the burst; no done pulse is produced.
- clk_en low: q, ser_out, FSM, counter and busy hold. done is cleared at the next enabled edge only, so a pending done is stretched while clk_en is low.
- Shift definitions:
  - Left: q <= {q[W-2:0], fill}; bit out = q[W-1].
  - Right: q <= {fill, q[W-1:1]}; bit out = q[0].
  - fill = bit out if rotate=1, else ser_in.
  - Every shift loads ser_out with the bit out. Load and hold leave ser_out unchanged.
- FSM states: IDLE, SHIFT.
- IDLE, enabled edge:
  - start=1, amt=0: q unchanged, stay IDLE, done=1 next cycle. mode is ignored.
  - start=1, amt>0: latch dir and rotate, counter=amt, busy=1, go to SHIFT. No shift occurs on this edge; mode is ignored.
  - start=0: apply mode with a single-step shift; done=0.
- SHIFT, enabled edge:
  - Perform one shift using the latched dir/rotate and the live ser_in; counter decrements.
  - When the counter goes 1->0: return to IDLE, busy=0, done=1 for the following cycle.
  - mode, start, d, dir and amt are ignored while in SHIFT.
- Latency:
  - Mode operations: result visible one edge after sampling.
  - Burst of N: busy high for N enabled cycles after the start edge; q final and done=1 after N+1 enabled edges counted from start.
- amt larger than WIDTH is legal. Shifting continues the full count; rotate results repeat with period WIDTH.
- start held high: a new burst can begin on the enabled edge after done (IDLE with done=1 accepts start).
- done and busy are never high together.

Test Plan:
1. Reset:
   - Set d=0xFF, mode=01, clk_en=1, and toggle clk, then assert rst_n=0 between edges -> q=0x00, busy=0, done=0, ser_out=0 immediately, before any clock edge.
   - Hold rst_n=0 across two edges -> q stays 0x00.
2. Load and enable:
   - mode=01, d=0xA5, one edge -> q=0xA5.
   - clk_en=0, d=0x3C, mode=01, two edges -> q stays 0xA5.
3. Single-step shifts:
   - From 0xA5, mode=10, rotate=0, ser_in=1 -> q=0x4B, ser_out=1.
   - Reload 0xA5, mode=11, rotate=1 -> q=0xD2, ser_out=1.
   - mode=00 -> q holds.
4. Burst rotate:
   - q=0x81, start=1, dir=0, rotate=1, amt=3 -> busy=1 for 3 cycles; q steps 0x03, 0x06, 0x0C; ser_out=0.
   - Then done=1 for exactly one cycle with busy=0.
   - mode=01 during busy has no effect.
5. Burst stall and zero count:
   - Right burst from 0xF0, rotate=0, ser_in=0, amt=4, with clk_en=0 for 2 cycles mid-burst -> q frozen while clk_en=0; final q=0x0F; busy lasts 6 cycles.
   - amt=0 -> q unchanged, busy stays 0, done pulses once.
6. Reset mid-burst:
   - amt=7, assert rst_n after 2 shifts -> q=0x00, busy=0, no done pulse.
   - After release, load 0x01 and burst left amt=1 -> q=0x02, done pulses.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold, parallel load, single-step shift/rotate,
// plus a multi-cycle burst-shift engine with busy/done status.
// Every state element advances only on enabled clock edges (clk_en high).
module univ_shift_reg #(
  parameter int unsigned             WIDTH     = 8,
  parameter logic [WIDTH-1:0]        RESET_VAL = '0,
  parameter int unsigned             AW        = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic             dir,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeLoad  = 2'b01;
  localparam logic [1:0] ModeLeft  = 2'b10;
  localparam logic [1:0] ModeRight = 2'b11;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic              rot_q, rot_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              sout_q, sout_d;

  // Decoded control from the FSM to the datapath
  logic              idle_start;
  logic              burst_step;
  logic              burst_last;

  // One shift step; returns {bit_out, new_value}
  function automatic logic [WIDTH:0] shift_once(input logic [WIDTH-1:0] val,
                                                input logic             right,
                                                input logic             rot,
                                                input logic             fill_in);
    logic bit_out;
    logic fill;
    bit_out = right ? val[0] : val[WIDTH-1];
    fill    = rot ? bit_out : fill_in;
    if (right) begin
      return {bit_out, fill, val[WIDTH-1:1]};
    end
    return {bit_out, val[WIDTH-2:0], fill};
  endfunction

  // FSM state register: state, burst counter and latched burst controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      done_q  <= done_d;
    end
  end

  // FSM next state: accept bursts in idle, count them down in shift
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    rot_d      = rot_q;
    done_d     = done_q;
    idle_start = 1'b0;
    burst_step = 1'b0;
    burst_last = 1'b0;
    if (clk_en) begin
      // done is a single enabled-cycle pulse; stretched only while clk_en is low
      done_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            idle_start = 1'b1;
            if (amt == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = StShift;
              cnt_d   = amt;
              dir_d   = dir;
              rot_d   = rotate;
            end
          end
        end
        StShift: begin
          burst_step = 1'b1;
          cnt_d      = cnt_q - AW'(1);
          if (cnt_q == AW'(1)) begin
            burst_last = 1'b1;
            state_d    = StIdle;
            done_d     = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath next state: burst shift, or the idle-time mode operation
  always_comb begin
    logic [WIDTH:0] shifted;
    data_d  = data_q;
    sout_d  = sout_q;
    shifted = '0;
    if (clk_en) begin
      if (burst_step) begin
        shifted = shift_once(data_q, dir_q, rot_q, ser_in);
        sout_d  = shifted[WIDTH];
        data_d  = shifted[WIDTH-1:0];
      end else if ((state_q == StIdle) && !idle_start) begin
        unique case (mode)
          ModeHold: data_d = data_q;
          ModeLoad: data_d = d;
          ModeLeft: begin
            shifted = shift_once(data_q, 1'b0, rotate, ser_in);
            sout_d  = shifted[WIDTH];
            data_d  = shifted[WIDTH-1:0];
          end
          ModeRight: begin
            shifted = shift_once(data_q, 1'b1, rotate, ser_in);
            sout_d  = shifted[WIDTH];
            data_d  = shifted[WIDTH-1:0];
          end
          default: data_d = data_q;
        endcase
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VAL;
      sout_q <= 1'b0;
    end else begin
      data_q <= data_d;
      sout_q <= sout_d;
    end
  end

  // Outputs: busy follows the shift state, done is the registered pulse
  always_comb begin
    q       = data_q;
    ser_out = sout_q;
    busy    = (state_q == StShift);
    done    = done_q;
  end

  // burst_last is informational for the counter path; keep it observable to lint
  logic unused_burst_last;
  assign unused_burst_last = burst_last;

  // busy and done describe mutually exclusive phases of a burst
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(busy && done)) else $error("busy and done high together");
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8) against a behavioural model.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clk_en;
  logic [1:0]    mode;
  logic          rotate;
  logic          ser_in;
  logic [W-1:0]  d;
  logic          start;
  logic          dir;
  logic [AW-1:0] amt;
  logic [W-1:0]  q;
  logic          ser_out;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [W-1:0] m_q;
  logic         m_so;
  logic         m_busy;
  logic         m_done;
  logic         m_dir;
  logic         m_rot;
  int           m_rem;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .mode    (mode),
    .rotate  (rotate),
    .ser_in  (ser_in),
    .d       (d),
    .start   (start),
    .dir     (dir),
    .amt     (amt),
    .q       (q),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q = '0; m_so = 0; m_busy = 0; m_done = 0; m_dir = 0; m_rot = 0; m_rem = 0;
  endtask

  task automatic model_shift(input logic right, input logic rot, input logic sin);
    logic out;
    logic fill;
    out  = right ? m_q[0] : m_q[W-1];
    fill = rot ? out : sin;
    if (right) m_q = (m_q >> 1) | (W'(fill) << (W - 1));
    else       m_q = (m_q << 1) | W'(fill);
    m_so = out;
  endtask

  // Apply one clock edge to the model using the inputs present at that edge
  task automatic model_edge();
    logic nd;
    if (!rst_n || !clk_en) return;
    nd = 0;
    if (m_busy) begin
      model_shift(m_dir, m_rot, ser_in);
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_busy = 0;
        nd = 1;
      end
    end else if (start) begin
      if (amt == 0) nd = 1;
      else begin
        m_busy = 1; m_rem = int'(amt); m_dir = dir; m_rot = rotate;
      end
    end else begin
      case (mode)
        2'b01: m_q = d;
        2'b10: model_shift(1'b0, rotate, ser_in);
        2'b11: model_shift(1'b1, rotate, ser_in);
        default: ;
      endcase
    end
    m_done = nd;
  endtask

  // Advance one clock; returns at the following falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    d = 8'hFF; mode = 2'b01; clk_en = 1;
    step();
    total++;
    if (q !== 8'hFF) begin bad++; $display("FAIL pre_reset_load q=%h want=ff", q); end
    rst_n = 0;
    #1;
    model_reset();
    total++;
    if (q !== 8'h00) begin bad++; $display("FAIL async_reset_q q=%h want=00", q); end
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
      bad++; $display("FAIL async_reset_flags busy=%b done=%b ser_out=%b want=000", busy, done,
                      ser_out);
    end
    step();
    step();
    total++;
    if (q !== 8'h00) begin bad++; $display("FAIL reset_hold q=%h want=00", q); end
    rst_n = 1;
  endtask

  task automatic test_load_enable();
    mode = 2'b01; d = 8'hA5; clk_en = 1;
    step();
    total++;
    if (q !== 8'hA5) begin bad++; $display("FAIL load q=%h want=a5", q); end
    clk_en = 0; d = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (q !== 8'hA5) begin bad++; $display("FAIL en_low_hold q=%h want=a5", q); end
    end
    clk_en = 1;
  endtask

  task automatic test_single_shift();
    mode = 2'b10; rotate = 0; ser_in = 1;
    step();
    total++;
    if (q !== 8'h4B || ser_out !== 1'b1) begin
      bad++; $display("FAIL shl_fill q=%h so=%b want=4b/1", q, ser_out);
    end
    mode = 2'b01; d = 8'hA5;
    step();
    mode = 2'b11; rotate = 1;
    step();
    total++;
    if (q !== 8'hD2 || ser_out !== 1'b1) begin
      bad++; $display("FAIL shr_rot q=%h so=%b want=d2/1", q, ser_out);
    end
    mode = 2'b00;
    step();
    total++;
    if (q !== 8'hD2 || ser_out !== 1'b1) begin
      bad++; $display("FAIL hold q=%h so=%b want=d2/1", q, ser_out);
    end
  endtask

  task automatic test_burst_rotate();
    logic [W-1:0] exp_q [3] = '{8'h03, 8'h06, 8'h0C};
    mode = 2'b01; d = 8'h81;
    step();
    start = 1; dir = 0; rotate = 1; amt = 4'd3;
    step();
    start = 0; mode = 2'b01; d = 8'hFF; // load must be ignored while busy
    total++;
    if (busy !== 1'b1 || q !== 8'h81) begin
      bad++; $display("FAIL burst_start busy=%b q=%h want=1/81", busy, q);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mode = 2'b00;
      step();
      total++;
      if (q !== exp_q[i] || q !== m_q) begin
        bad++; $display("FAIL burst_step%0d q=%h want=%h", i, q, exp_q[i]);
      end
      total++;
      if (busy !== (i < 2) || done !== (i == 2)) begin
        bad++; $display("FAIL burst_flags%0d busy=%b done=%b want=%b/%b", i, busy, done, i < 2,
                        i == 2);
      end
    end
    total++;
    if (ser_out !== 1'b0) begin bad++; $display("FAIL burst_ser_out so=%b want=0", ser_out); end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL done_one_cycle done=%b busy=%b want=0/0", done, busy);
    end
  endtask

  task automatic test_burst_stall();
    int busy_cycles;
    int guard;
    mode = 2'b01; d = 8'hF0;
    step();
    mode = 2'b00; start = 1; dir = 1; rotate = 0; ser_in = 0; amt = 4'd4;
    step();
    start = 0; dir = 0; amt = 4'd9;
    busy_cycles = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 20) begin
      busy_cycles++;
      clk_en = !(guard == 2 || guard == 3);
      step();
      if (!clk_en) begin
        total++;
        if (q !== m_q) begin bad++; $display("FAIL stall_freeze q=%h want=%h", q, m_q); end
      end
      guard++;
    end
    clk_en = 1;
    total++;
    if (guard >= 20) begin bad++; $display("FAIL stall_timeout guard=%0d want<20", guard); end
    total++;
    if (busy_cycles !== 6) begin
      bad++; $display("FAIL stall_busy_len got=%0d want=6", busy_cycles);
    end
    total++;
    if (q !== 8'h0F || done !== 1'b1) begin
      bad++; $display("FAIL stall_final q=%h done=%b want=0f/1", q, done);
    end
    step();
    start = 1; amt = 4'd0; mode = 2'b01; d = 8'h55;
    step();
    start = 0; mode = 2'b00;
    total++;
    if (q !== 8'h0F || busy !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL zero_amt q=%h busy=%b done=%b want=0f/0/1", q, busy, done);
    end
    step();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL zero_amt_pulse done=%b want=0", done); end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    start = 1; dir = 0; rotate = 1; amt = 4'd7;
    step();
    start = 0;
    step();
    step();
    rst_n = 0;
    #1;
    model_reset();
    total++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL mid_reset q=%h busy=%b done=%b want=00/0/0", q, busy, done);
    end
    step();
    rst_n = 1;
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    total++;
    if (seen_done != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", seen_done); end
    mode = 2'b01; d = 8'h01;
    step();
    mode = 2'b00; start = 1; dir = 0; rotate = 0; ser_in = 0; amt = 4'd1;
    step();
    start = 0;
    step();
    total++;
    if (q !== 8'h02 || done !== 1'b1) begin
      bad++; $display("FAIL post_reset_burst q=%h done=%b want=02/1", q, done);
    end
  endtask

  task automatic test_back_to_back();
    mode = 2'b00; start = 1; dir = 1; rotate = 1; amt = 4'd2;
    for (int i = 0; i < 4; i++) step();
    // start edge, two shifts (done), then a new burst is accepted
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || q !== m_q) begin
      bad++; $display("FAIL back_to_back busy=%b done=%b q=%h want=1/0/%h", busy, done, q, m_q);
    end
    start = 0;
    step();
    step();
    total++;
    if (done !== 1'b1 || q !== m_q) begin
      bad++; $display("FAIL back_to_back_end done=%b q=%h want=1/%h", done, q, m_q);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clk_en = ($urandom_range(0, 5) != 0);
      mode   = 2'($urandom_range(0, 3));
      rotate = 1'($urandom_range(0, 1));
      ser_in = 1'($urandom_range(0, 1));
      d      = 8'($urandom);
      start  = ($urandom_range(0, 6) == 0);
      dir    = 1'($urandom_range(0, 1));
      amt    = 4'($urandom_range(0, 12));
      step();
      total++;
      if (q !== m_q || ser_out !== m_so || busy !== m_busy || done !== m_done) begin
        bad++;
        $display("FAIL rand%0d q=%h so=%b busy=%b done=%b want=%h/%b/%b/%b", i, q, ser_out,
                 busy, done, m_q, m_so, m_busy, m_done);
      end
    end
    start = 0; clk_en = 1;
  endtask

  initial begin
    rst_n = 0; clk_en = 0; mode = 0; rotate = 0; ser_in = 0; d = '0;
    start = 0; dir = 0; amt = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    test_reset();
    test_load_enable();
    test_single_shift();
    test_burst_rotate();
    test_burst_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
